cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 108 ++++++++++
 tb/tb_cdb_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Purpose  : round-robin arbiter granting up to NUM_PORTS of NUM_REQ functional-unit write-backs onto the CDB.
// Latency  : grant (req_ready) is combinational; the granted payload is broadcast on the CDB one cycle later.
// Backpress: a requester waits (ready=0) until the rotating scan reaches it; nothing is queued, and flush drops all grants.
//
// Ports:
//   clk_i, reset_i           clock, asynchronous active-low reset
//   req_valid_i/req_data_i   per-FU write-back request and payload
//   req_ready_o              per-FU grant, transfer on valid & ready
//   flush_i                  mispredict flush: no grants this cycle, pointer back to 0
//   cdb_valid_o/cdb_o        per-port broadcast valid and payload (registered)
//   cdb_src_o                per-port index of the requester that won the port
//   grant_cnt_o              free-running count of transfers since reset (wraps)
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2,
  // Defaults to the ROB write-back record width; the payload is opaque here.
  parameter int WB_W      = 64,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  input  logic [NUM_REQ-1:0][WB_W-1:0]         req_data_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic                                 flush_i,
  output logic [NUM_PORTS-1:0]                 cdb_valid_o,
  output logic [NUM_PORTS-1:0][WB_W-1:0]       cdb_o,
  output logic [NUM_PORTS-1:0][SRC_W-1:0]      cdb_src_o,
  output logic [31:0]                          grant_cnt_o
);

  logic [SRC_W-1:0]                  rr_q;
  logic [NUM_PORTS-1:0]              cdb_valid_q;
  logic [NUM_PORTS-1:0][WB_W-1:0]    cdb_q;
  logic [NUM_PORTS-1:0][SRC_W-1:0]   cdb_src_q;
  logic [31:0]                       grant_cnt_q;

  logic [NUM_REQ-1:0]                gnt;
  logic [NUM_PORTS-1:0]              port_vld;
  logic [NUM_PORTS-1:0][SRC_W-1:0]   port_src;
  logic [NUM_PORTS-1:0][WB_W-1:0]    port_dat;
  int                                n_gnt;
  int                                last_idx;
  int                                n_xfer;
  logic [SRC_W-1:0]                  rr_next;

  // Scan requesters starting at rr_q; the k-th valid one found takes port k.
  // The inner loops compare against constant indices so every select is static.
  always_comb begin
    gnt      = '0;
    port_vld = '0;
    port_src = '0;
    port_dat = '0;
    n_gnt    = 0;
    last_idx = int'(rr_q);
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if ((r == (int'(rr_q) + i) % NUM_REQ) && req_valid_i[r] && (n_gnt < NUM_PORTS)) begin
          gnt[r] = 1'b1;
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (p == n_gnt) begin
              port_vld[p] = 1'b1;
              port_src[p] = SRC_W'(r);
              port_dat[p] = req_data_i[r];
            end
          end
          last_idx = r;
          n_gnt    = n_gnt + 1;
        end
      end
    end
  end

  // Flush and reset both kill every grant in the current cycle.
  assign req_ready_o = (reset_i && !flush_i) ? (gnt & req_valid_i) : '0;
  assign n_xfer      = flush_i ? 0 : n_gnt;
  assign rr_next     = SRC_W'((last_idx + 1) % NUM_REQ);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rr_q        <= '0;
      cdb_valid_q <= '0;
      cdb_q       <= '0;
      cdb_src_q   <= '0;
      grant_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_q + 32'(n_xfer);
      cdb_q       <= port_dat;
      cdb_src_q   <= port_src;
      if (flush_i) begin
        rr_q        <= '0;
        cdb_valid_q <= '0;
      end else begin
        cdb_valid_q <= port_vld;
        // Pointer moves past the last winner only when something was granted.
        if (n_gnt > 0) begin
          rr_q <= rr_next;
        end
      end
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_o       = cdb_q;
  assign cdb_src_o   = cdb_src_q;
  assign grant_cnt_o = grant_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int NR = 4;
  localparam int NP = 2;
  localparam int W  = 8;
  localparam int SW = 2;

  logic                     clk = 1'b0;
  logic                     reset_i = 1'b0;
  logic [NR-1:0]            req_valid = '0;
  logic [NR-1:0][W-1:0]     req_data = '0;
  logic [NR-1:0]            req_ready;
  logic                     flush = 1'b0;
  logic [NP-1:0]            cdb_valid;
  logic [NP-1:0][W-1:0]     cdb_dat;
  logic [NP-1:0][SW-1:0]    cdb_src;
  logic [31:0]              grant_cnt;

  int checks = 0;
  int failures = 0;
  int rst_pulses = 0;

  cdb_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .WB_W(W)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .flush_i     (flush),
    .cdb_valid_o (cdb_valid),
    .cdb_o       (cdb_dat),
    .cdb_src_o   (cdb_src),
    .grant_cnt_o (grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pointer, transfer count and the broadcast expected next cycle.
  int                    m_rr = 0;
  int unsigned           m_cnt = 0;
  logic [NP-1:0]         e_vld = '0;
  logic [NP-1:0][W-1:0]  e_dat = '0;
  logic [NP-1:0][SW-1:0] e_src = '0;
  logic [NR-1:0]         e_rdy;
  int                    seen_pulses = 0;
  int                    winners[$];

  always @(negedge clk) begin
    if (!reset_i || seen_pulses != rst_pulses) begin
      seen_pulses = rst_pulses;
      m_rr  = 0;
      m_cnt = 0;
      e_vld = '0;
    end
    if (!reset_i) begin
      chk("m_rst_rdy", req_ready, 0);
      chk("m_rst_vld", cdb_valid, 0);
      chk("m_rst_cnt", grant_cnt, 0);
    end else begin
      chk("m_vld", cdb_valid, e_vld);
      for (int k = 0; k < NP; k++) begin
        if (e_vld[k]) begin
          chk("m_dat", cdb_dat[k], e_dat[k]);
          chk("m_src", cdb_src[k], e_src[k]);
        end
      end
      chk("m_cnt", grant_cnt, m_cnt);
      // Winners: first NP valid requesters visiting m_rr, m_rr+1, ... mod NR.
      winners = {};
      for (int i = 0; i < NR; i++) begin
        if (req_valid[(m_rr + i) % NR] && winners.size() < NP)
          winners.push_back((m_rr + i) % NR);
      end
      e_rdy = '0;
      if (!flush) foreach (winners[j]) e_rdy[winners[j]] = 1'b1;
      chk("m_rdy", req_ready, e_rdy);
      e_vld = '0;
      if (flush) begin
        m_rr = 0;
      end else begin
        foreach (winners[j]) begin
          e_vld[j] = 1'b1;
          e_dat[j] = req_data[winners[j]];
          e_src[j] = SW'(winners[j]);
        end
        m_cnt += winners.size();
        if (winners.size() > 0) m_rr = (winners[winners.size()-1] + 1) % NR;
      end
    end
  end

  // Directed table run after the literal scenarios: {flush, valid}.
  logic [4:0] vec [0:9];

  initial begin
    vec[0] = 5'b0_0001; vec[1] = 5'b0_1000; vec[2] = 5'b0_0110; vec[3] = 5'b1_1111;
    vec[4] = 5'b0_0000; vec[5] = 5'b0_1110; vec[6] = 5'b0_0101; vec[7] = 5'b0_1111;
    vec[8] = 5'b0_1001; vec[9] = 5'b0_0000;

    // Reset held, then idle.
    repeat (2) @(negedge clk);
    chk("rst_vld", cdb_valid, 0);
    chk("rst_cnt", grant_cnt, 0);
    @(posedge clk); #1 reset_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_vld", cdb_valid, 0);
      chk("idle_cnt", grant_cnt, 0);
    end

    // Single request from requester 2.
    @(posedge clk); #1 req_valid = 4'b0100; req_data[2] = 8'hAB;
    @(negedge clk); chk("single_rdy", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid = '0; req_data = '0;
    @(negedge clk);
    chk("single_vld", cdb_valid, 2'b01);
    chk("single_dat", cdb_dat[0], 8'hAB);
    chk("single_src", cdb_src[0], 2);
    chk("single_rr", dut.rr_q, 3);
    chk("single_cnt", grant_cnt, 1);

    // Wrap-around from rr=3.
    @(posedge clk); #1 req_valid = 4'b1011; req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    @(negedge clk); chk("wrap_rdy", req_ready, 4'b1001);

    // Flush with everyone valid; the wrap broadcast already visible must survive.
    @(posedge clk); #1 req_valid = 4'b1111; flush = 1'b1;
    @(negedge clk);
    chk("wrap_vld", cdb_valid, 2'b11);
    chk("wrap_src0", cdb_src[0], 3);
    chk("wrap_src1", cdb_src[1], 0);
    chk("wrap_dat0", cdb_dat[0], 8'hD3);
    chk("wrap_dat1", cdb_dat[1], 8'hD0);
    chk("wrap_rr", dut.rr_q, 1);
    chk("flush_rdy", req_ready, 4'b0000);
    chk("flush_cnt_t", grant_cnt, 3);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_vld", cdb_valid, 2'b00);
    chk("flush_rr", dut.rr_q, 0);
    chk("flush_cnt", grant_cnt, 3);
    chk("all_rdy1", req_ready, 4'b0011);

    // All four valid continuously from rr=0.
    @(posedge clk); #1;
    @(negedge clk);
    chk("all_src_a", {cdb_valid, cdb_src[1], cdb_src[0]}, {2'b11, 2'd1, 2'd0});
    chk("all_rdy2", req_ready, 4'b1100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("all_src_b", {cdb_valid, cdb_src[1], cdb_src[0]}, {2'b11, 2'd3, 2'd2});
    chk("all_rdy3", req_ready, 4'b0011);
    @(posedge clk); #1;
    @(negedge clk);
    chk("all_cnt", grant_cnt, 3 + 6);

    // Asynchronous reset mid-stream while both ports broadcast.
    @(posedge clk); #2;
    chk("mid_pre_vld", cdb_valid, 2'b11);
    rst_pulses++;
    reset_i = 1'b0;
    #1;
    chk("mid_vld", cdb_valid, 2'b00);
    chk("mid_dat", cdb_dat, 0);
    chk("mid_src", cdb_src, 0);
    chk("mid_cnt", grant_cnt, 0);
    chk("mid_rdy", req_ready, 4'b0000);
    #1 reset_i = 1'b1;
    @(negedge clk); chk("resume_rdy", req_ready, 4'b0011);
    repeat (3) @(negedge clk);
    chk("resume_cnt", grant_cnt, 6);

    // Directed table, checked by the model every cycle.
    for (int v = 0; v < 10; v++) begin
      @(posedge clk); #1;
      flush     = vec[v][4];
      req_valid = vec[v][3:0];
      for (int r = 0; r < NR; r++) req_data[r] = 8'(16 * v + r + 1);
    end
    @(posedge clk); #1 req_valid = '0; flush = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
